// File: rtl/scan_decoder.sv
// scan_decoder
//   Registered 1-of-OUTS decoder with two sources for the selected output:
//   the sel input directly (mode=0) or an internal scan index (mode=1) that
//   can be loaded from sel and stepped up or down with wrap-around.
//
// Parameters
//   N          select/index width, 1..6; OUTS = 2**N outputs
//   ACTIVE_LOW 1 inverts every bit of y at the port
//
// Ports
//   clk    in   1     rising-edge clock
//   rst_n  in   1     asynchronous active-low reset
//   en     in   1     output enable; 0 forces y inactive
//   mode   in   1     0 = decode sel, 1 = decode scan index
//   sel    in   N     direct select value / scan load value
//   load   in   1     scan: idx <= sel (wins over step)
//   step   in   1     scan: advance idx by one per cycle
//   dir    in   1     step direction, 0 = up, 1 = down
//   y      out  OUTS  one-hot decode, bit k = logical output k+1
//   idx    out  N     current scan index
//   wrap   out  1     one-cycle pulse when a step wraps the index
module scan_decoder #(
  parameter int N          = 2,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                mode,
  input  logic [N-1:0]        sel,
  input  logic                load,
  input  logic                step,
  input  logic                dir,
  output logic [(1<<N)-1:0]   y,
  output logic [N-1:0]        idx,
  output logic                wrap
);

  localparam int OUTS = 1 << N;
  localparam logic [N-1:0] IDX_ONE = 1;
  localparam logic [N-1:0] IDX_MAX = '1;
  localparam logic [N-1:0] IDX_MIN = '0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    idx_q, idx_d;
  logic [N-1:0]    sel_q, sel_d;
  logic            wrap_q, wrap_d;
  logic [OUTS-1:0] y_logic;

  // Next state depends only on the current inputs; the state register then
  // selects which registered value (captured sel or scan index) drives y.
  always_comb begin
    state_d = IDLE;
    if (en) begin
      state_d = mode ? SCAN : DIRECT;
    end
  end

  // Scan index: only moves when enabled in scan mode; load beats step and
  // never raises wrap, even when loading 0 or OUTS-1.
  always_comb begin
    idx_d  = idx_q;
    wrap_d = 1'b0;
    if (en && mode) begin
      if (load) begin
        idx_d = sel;
      end else if (step) begin
        if (dir) begin
          idx_d  = idx_q - IDX_ONE;
          wrap_d = (idx_q == IDX_MIN);
        end else begin
          idx_d  = idx_q + IDX_ONE;
          wrap_d = (idx_q == IDX_MAX);
        end
      end
    end
  end

  // Direct select is captured every enabled direct-mode cycle so the decode
  // below only ever sees registered values (one cycle of latency).
  always_comb begin
    sel_d = sel_q;
    if (en && !mode) begin
      sel_d = sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      sel_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      wrap_q  <= wrap_d;
    end
  end

  // Decode from registered state only: a single index feeds the decoder, so
  // y is one-hot or all-zero by construction. Reset forces IDLE at once,
  // which clears y asynchronously.
  always_comb begin
    y_logic = '0;
    case (state_q)
      DIRECT:  y_logic[sel_q] = 1'b1;
      SCAN:    y_logic[idx_q] = 1'b1;
      default: y_logic = '0;
    endcase
  end

  assign y    = ACTIVE_LOW ? ~y_logic : y_logic;
  assign idx  = idx_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_scan_decoder.sv
module tb_scan_decoder;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       mode;
  logic [1:0] sel;
  logic       load;
  logic       step;
  logic       dir;
  logic [3:0] y;
  logic [1:0] idx;
  logic       wrap;
  logic [3:0] y_al;
  logic [1:0] idx_al;
  logic       wrap_al;

  int total;
  int bad;

  scan_decoder #(.N(2), .ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel),
    .load(load), .step(step), .dir(dir), .y(y), .idx(idx), .wrap(wrap)
  );

  scan_decoder #(.N(2), .ACTIVE_LOW(1'b1)) dut_al (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel),
    .load(load), .step(step), .dir(dir), .y(y_al), .idx(idx_al), .wrap(wrap_al)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       en;
    logic       mode;
    logic [1:0] sel;
    logic       load;
    logic       step;
    logic       dir;
    logic [3:0] exp_y;
    logic [1:0] exp_idx;
    logic       exp_wrap;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] ey, input logic [1:0] ei,
                         input logic ew);
    chk({tag, ".y"}, {28'd0, y}, {28'd0, ey});
    chk({tag, ".idx"}, {30'd0, idx}, {30'd0, ei});
    chk({tag, ".wrap"}, {31'd0, wrap}, {31'd0, ew});
    chk({tag, ".y_al"}, {28'd0, y_al}, {28'd0, ~ey});
    $display("%s: y=%b idx=%0d wrap=%b y_al=%b", tag, y, idx, wrap, y_al);
  endtask

  task automatic drive(input logic e, input logic m, input logic [1:0] s,
                       input logic l, input logic st, input logic d);
    en = e; mode = m; sel = s; load = l; step = st; dir = d;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    //            en mode sel    load step dir  exp_y    idx   wrap
    vecs[0]  = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 4'b0001, 2'd0, 1'b0}; // direct sweep
    vecs[1]  = '{1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 4'b0010, 2'd0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 4'b0100, 2'd0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 4'b1000, 2'd0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0}; // en gating
    vecs[5]  = '{1'b0, 1'b1, 2'd3, 1'b1, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0}; // no load while idle
    vecs[6]  = '{1'b1, 1'b1, 2'd3, 1'b1, 1'b0, 1'b0, 4'b1000, 2'd3, 1'b0}; // load 3, no wrap
    vecs[7]  = '{1'b1, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 4'b0001, 2'd0, 1'b1}; // up wrap
    vecs[8]  = '{1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 4'b0001, 2'd0, 1'b0}; // wrap one cycle only
    vecs[9]  = '{1'b1, 1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 4'b1000, 2'd3, 1'b1}; // down wrap
    vecs[10] = '{1'b1, 1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b0}; // further down
    vecs[11] = '{1'b1, 1'b1, 2'd1, 1'b1, 1'b1, 1'b0, 4'b0010, 2'd1, 1'b0}; // load beats step
    vecs[12] = '{1'b1, 1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b0}; // load 0 no wrap
    vecs[13] = '{1'b1, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 4'b0010, 2'd1, 1'b0}; // held step x3
    vecs[14] = '{1'b1, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 4'b0100, 2'd2, 1'b0};
    vecs[15] = '{1'b1, 1'b0, 2'd3, 1'b0, 1'b1, 1'b0, 4'b1000, 2'd2, 1'b0}; // direct: idx holds
    vecs[16] = '{1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 4'b0100, 2'd2, 1'b0}; // resume scan
    vecs[17] = '{1'b1, 1'b1, 2'd2, 1'b1, 1'b1, 1'b0, 4'b0100, 2'd2, 1'b0}; // priority sel=2
    vecs[18] = '{1'b1, 1'b1, 2'd3, 1'b1, 1'b0, 1'b0, 4'b1000, 2'd3, 1'b0}; // load max no wrap
    vecs[19] = '{1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 4'b0000, 2'd3, 1'b0}; // idle: idx holds

    drive(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #12;
    chk_all("reset", 4'b0000, 2'd0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].en, vecs[i].mode, vecs[i].sel, vecs[i].load, vecs[i].step, vecs[i].dir);
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", i), vecs[i].exp_y, vecs[i].exp_idx, vecs[i].exp_wrap);
    end

    // Async reset mid-scan between edges with idx=2 and load/step in flight.
    drive(1'b1, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk_all("preload2", 4'b0100, 2'd2, 1'b0);
    drive(1'b1, 1'b1, 2'd3, 1'b1, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 4'b0000, 2'd0, 1'b0);
    @(posedge clk);
    #1;
    chk_all("rst_held", 4'b0000, 2'd0, 1'b0);
    drive(1'b1, 1'b1, 2'd0, 1'b0, 1'b1, 1'b1);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_all("first_after_rst", 4'b1000, 2'd3, 1'b1);
    drive(1'b1, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk_all("step_up_wrap", 4'b0001, 2'd0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: run did not finish, expected finish before 100000");
    $fatal(1);
  end

endmodule
